// File: rtl/shift_latch_pkg.sv
// Shared types and width helpers for the 74595-chain sequencer.
// Holds the FSM state encoding and the counter-width functions.
// The readback feature is enabled by defining SHIFT_LATCH_CTRL_READBACK_EN.
package shift_latch_pkg;

  // Sequencer states: idle, shift-clock low phase, shift-clock high phase, latch pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Wide enough for any legal CLK_DIV (1..255)
  typedef logic [7:0] phase_cnt_t;

  // Bits needed to hold a bit count of 0..width
  function automatic int bit_cnt_w(input int width);
    return ($clog2(width + 1) < 1) ? 1 : $clog2(width + 1);
  endfunction

  // Bits needed to hold a phase count of 0..clk_div
  function automatic int phase_cnt_w(input int clk_div);
    return ($clog2(clk_div + 1) < 1) ? 1 : $clog2(clk_div + 1);
  endfunction

endpackage

// File: rtl/shift_latch_tick.sv
// Phase timer: counts CLK_DIV cycles per timed FSM phase.
// Latency: o_expire is high in the last cycle of a phase (CLK_DIV cycles after i_load).
// Backpressure: none; reloads whenever i_load is asserted, holds at zero otherwise.
module shift_latch_tick
  import shift_latch_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expire
);

  localparam int         CW     = phase_cnt_w(CLK_DIV);
  localparam phase_cnt_t RELOAD = phase_cnt_t'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Down-counter: reload on phase entry, stop at zero (never wraps)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD[CW-1:0];
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/shift_latch_ctrl.sv
// Serialises a parallel word into a 74595 chain (SER/SRCLK) then pulses RCLK.
// Latency: done fires (2*WIDTH+1)*CLK_DIV+1 cycles after the accepting edge.
// Backpressure: din_ready low while a transfer is in flight; optional readback via SHIFT_LATCH_CTRL_READBACK_EN.
module shift_latch_ctrl
  import shift_latch_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             oe_n,
  output logic             busy,
  output logic             done
`ifdef SHIFT_LATCH_CTRL_READBACK_EN
  ,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout
`endif
);

  localparam int BW = bit_cnt_w(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [BW-1:0]    r_bits;
  logic             r_ser;
  logic             r_srclk;
  logic             r_rclk;
  logic             r_oe_n;
  logic             r_busy;
  logic             r_done;

  logic             w_ready;
  logic             w_start;
  logic             w_expire;
  logic             w_load;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_first_bit;
  logic             w_next_bit;

  assign w_ready = ~r_busy & ~rst;
  assign w_start = din_valid & w_ready;
  // Reload the phase timer on every entry into a timed state
  assign w_load  = w_start | (r_busy & w_expire);

  assign w_sh_next   = (MSB_FIRST != 0) ? (r_sh << 1) : (r_sh >> 1);
  assign w_first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign w_next_bit  = (MSB_FIRST != 0) ? w_sh_next[WIDTH-1] : w_sh_next[0];

  shift_latch_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  // Main sequencer: state plus all registered chain-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bits  <= '0;
      r_ser   <= 1'b0;
      r_srclk <= 1'b0;
      r_rclk  <= 1'b0;
      r_oe_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_sh    <= din;
            r_ser   <= w_first_bit;
            r_bits  <= BW'(WIDTH);
            r_srclk <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SH_LO;
          end
        end
        SH_LO: begin
          if (w_expire) begin
            r_srclk <= 1'b1;
            r_state <= SH_HI;
          end
        end
        SH_HI: begin
          if (w_expire) begin
            r_srclk <= 1'b0;
            if (r_bits != BW'(1)) begin
              r_bits  <= r_bits - BW'(1);
              r_sh    <= w_sh_next;
              r_ser   <= w_next_bit;
              r_state <= SH_LO;
            end else begin
              r_bits  <= '0;
              r_ser   <= 1'b0;
              r_rclk  <= 1'b1;
              r_state <= LATCH;
            end
          end
        end
        LATCH: begin
          if (w_expire) begin
            r_rclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            // First completed latch means the chain now holds real data
            r_oe_n  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign din_ready = w_ready;
  assign ser       = r_ser;
  assign srclk     = r_srclk;
  assign rclk      = r_rclk;
  assign oe_n      = r_oe_n;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef SHIFT_LATCH_CTRL_READBACK_EN
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_rb_next;

  // Pack the incoming cascade bit in arrival order, same bit order as din
  always_comb begin
    w_rb_next = '0;
    if (MSB_FIRST != 0) begin
      w_rb_next    = r_rb << 1;
      w_rb_next[0] = ser_in;
    end else begin
      w_rb_next           = r_rb >> 1;
      w_rb_next[WIDTH-1]  = ser_in;
    end
  end

  // Sample QH' at the end of each high phase; publish the word as the latch completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb   <= '0;
      r_dout <= '0;
    end else begin
      if ((r_state == SH_HI) && w_expire) begin
        r_rb <= w_rb_next;
      end
      if ((r_state == LATCH) && w_expire) begin
        r_dout <= r_rb;
      end
    end
  end

  assign dout = r_dout;
`endif

endmodule

// File: tb/tb_shift_latch_ctrl.sv
// Directed bench for shift_latch_ctrl: three configurations (8b/div2/MSB, 8b/div2/LSB, 1b/div1).
// A negedge monitor records serial bits, clock pulses and done timing per instance.
// Readback check is compiled in when SHIFT_LATCH_CTRL_READBACK_EN is defined.
module tb_shift_latch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] din_v   [3];
  logic        valid_v [3];
  logic        ready_w [3];
  logic        ser_w   [3];
  logic        srclk_w [3];
  logic        rclk_w  [3];
  logic        oe_n_w  [3];
  logic        busy_w  [3];
  logic        done_w  [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SHIFT_LATCH_CTRL_READBACK_EN
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic [0:0] dout2;
  logic [7:0] chain_q  = 8'h00;
  logic       chain_qh = 1'b0;
  // 8-bit chain model; chain_qh is the bit leaving stage H at each SRCLK rise
  always @(posedge srclk_w[0]) {chain_qh, chain_q} <= {chain_q, ser_w[0]};
`endif

  shift_latch_ctrl #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .din(din_v[0][7:0]), .din_valid(valid_v[0]), .din_ready(ready_w[0]),
    .ser(ser_w[0]), .srclk(srclk_w[0]), .rclk(rclk_w[0]), .oe_n(oe_n_w[0]), .busy(busy_w[0]),
    .done(done_w[0])
`ifdef SHIFT_LATCH_CTRL_READBACK_EN
    , .ser_in(chain_qh), .dout(dout0)
`endif
  );

  shift_latch_ctrl #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .din(din_v[1][7:0]), .din_valid(valid_v[1]), .din_ready(ready_w[1]),
    .ser(ser_w[1]), .srclk(srclk_w[1]), .rclk(rclk_w[1]), .oe_n(oe_n_w[1]), .busy(busy_w[1]),
    .done(done_w[1])
`ifdef SHIFT_LATCH_CTRL_READBACK_EN
    , .ser_in(1'b0), .dout(dout1)
`endif
  );

  shift_latch_ctrl #(.WIDTH(1), .CLK_DIV(1), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .din(din_v[2][0:0]), .din_valid(valid_v[2]), .din_ready(ready_w[2]),
    .ser(ser_w[2]), .srclk(srclk_w[2]), .rclk(rclk_w[2]), .oe_n(oe_n_w[2]), .busy(busy_w[2]),
    .done(done_w[2])
`ifdef SHIFT_LATCH_CTRL_READBACK_EN
    , .ser_in(1'b0), .dout(dout2)
`endif
  );

  // Monitor state (written only by the monitor below)
  logic [63:0] cap_bits     [3] = '{default: 64'd0};
  int          rise_cnt     [3] = '{default: 0};
  int          srclk_hi_cnt [3] = '{default: 0};
  int          rclk_hi_cnt  [3] = '{default: 0};
  int          rclk_pulse   [3] = '{default: 0};
  int          done_cnt     [3] = '{default: 0};
  int          done_cyc     [3] = '{default: 0};
  logic        srclk_q      [3] = '{default: 1'b0};
  logic        rclk_q       [3] = '{default: 1'b0};
  logic        oe_q         [3] = '{default: 1'b1};
  logic        oe_at_done   [3] = '{default: 1'b0};
  logic        oe_before    [3] = '{default: 1'b0};
  logic        busy_at_done [3] = '{default: 1'b0};

  // Sample every instance mid-cycle: serial bits at SRCLK rises, pulse widths, done timing
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (srclk_w[k] === 1'b1) begin
        srclk_hi_cnt[k] = srclk_hi_cnt[k] + 1;
        if (srclk_q[k] !== 1'b1) begin
          cap_bits[k] = {cap_bits[k][62:0], ser_w[k]};
          rise_cnt[k] = rise_cnt[k] + 1;
        end
      end
      if (rclk_w[k] === 1'b1) begin
        rclk_hi_cnt[k] = rclk_hi_cnt[k] + 1;
        if (rclk_q[k] !== 1'b1) rclk_pulse[k] = rclk_pulse[k] + 1;
      end
      if (done_w[k] === 1'b1) begin
        done_cnt[k]     = done_cnt[k] + 1;
        done_cyc[k]     = cyc;
        oe_at_done[k]   = oe_n_w[k];
        oe_before[k]    = oe_q[k];
        busy_at_done[k] = busy_w[k];
      end
      srclk_q[k] = srclk_w[k];
      rclk_q[k]  = rclk_w[k];
      oe_q[k]    = oe_n_w[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a word and wait for the handshake; hs is the cycle the handshake occurs in
  task automatic send(input int k, input logic [63:0] w, input bit keep, output int hs);
    bit ok;
    ok = 1'b0;
    hs = -1;
    din_v[k]   = w;
    valid_v[k] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (ready_w[k] === 1'b1) begin
        hs = cyc;
        ok = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) valid_v[k] = 1'b0;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      valid_v[k] = 1'b0;
      chk("handshake_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_done(input int k, input int target, output int dc);
    bit ok;
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (done_cnt[k] >= target) begin
        dc = done_cyc[k];
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    int          k;
    logic [63:0] din;
    logic [63:0] exp_bits;
    int          nbits;
    int          lat;
    int          rclk_hi;
    int          srclk_hi;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int hs, hs2, dc, d0, r0, rh0, rp0, sh0;
    logic [63:0] m;

    vecs[0] = '{k: 0, din: 64'hA5, exp_bits: 64'hA5, nbits: 8, lat: 35, rclk_hi: 2, srclk_hi: 16};
    vecs[1] = '{k: 1, din: 64'h01, exp_bits: 64'h80, nbits: 8, lat: 35, rclk_hi: 2, srclk_hi: 16};
    vecs[2] = '{k: 1, din: 64'h80, exp_bits: 64'h01, nbits: 8, lat: 35, rclk_hi: 2, srclk_hi: 16};
    vecs[3] = '{k: 2, din: 64'h1,  exp_bits: 64'h1,  nbits: 1, lat: 4,  rclk_hi: 1, srclk_hi: 1};
    vecs[4] = '{k: 2, din: 64'h0,  exp_bits: 64'h0,  nbits: 1, lat: 4,  rclk_hi: 1, srclk_hi: 1};
    vecs[5] = '{k: 0, din: 64'h3C, exp_bits: 64'h3C, nbits: 8, lat: 35, rclk_hi: 2, srclk_hi: 16};

    for (int k = 0; k < 3; k++) begin
      din_v[k]   = 64'd0;
      valid_v[k] = 1'b0;
    end

    // Reset state: {ready, ser, srclk, rclk, oe_n, busy, done}
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_state%0d", k),
          {ready_w[k], ser_w[k], srclk_w[k], rclk_w[k], oe_n_w[k], busy_w[k], done_w[k]},
          64'b0000100);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", ready_w[0], 1'b1);

    // Table-driven single transfers
    for (int i = 0; i < 6; i++) begin
      int k;
      k   = vecs[i].k;
      d0  = done_cnt[k];
      r0  = rise_cnt[k];
      rh0 = rclk_hi_cnt[k];
      rp0 = rclk_pulse[k];
      sh0 = srclk_hi_cnt[k];
      send(k, vecs[i].din, 1'b0, hs);
      wait_done(k, d0 + 1, dc);
      m = (64'd1 << vecs[i].nbits) - 64'd1;
      chk($sformatf("v%0d_bits", i), cap_bits[k] & m, vecs[i].exp_bits);
      chk($sformatf("v%0d_rises", i), rise_cnt[k] - r0, vecs[i].nbits);
      chk($sformatf("v%0d_latency", i), dc - hs, vecs[i].lat);
      chk($sformatf("v%0d_rclk_width", i), rclk_hi_cnt[k] - rh0, vecs[i].rclk_hi);
      chk($sformatf("v%0d_rclk_pulses", i), rclk_pulse[k] - rp0, 1);
      chk($sformatf("v%0d_srclk_high", i), srclk_hi_cnt[k] - sh0, vecs[i].srclk_hi);
      chk($sformatf("v%0d_oe_n_done", i), oe_at_done[k], 1'b0);
      chk($sformatf("v%0d_busy_done", i), busy_at_done[k], 1'b0);
      chk($sformatf("v%0d_ready_done", i), ready_w[k], 1'b1);
      if (i < 4 && vecs[i].k != vecs[(i == 0) ? 0 : i - 1].k || i == 0)
        chk($sformatf("v%0d_oe_n_before_first_done", i), oe_before[k], 1'b1);
    end

    // Back-to-back: valid held high, din changes while busy
    d0  = done_cnt[0];
    r0  = rise_cnt[0];
    rp0 = rclk_pulse[0];
    send(0, 64'h3C, 1'b1, hs);
    send(0, 64'hC3, 1'b0, hs2);
    chk("b2b_no_bubble", hs2 - hs, 35);
    wait_done(0, d0 + 2, dc);
    chk("b2b_second_latency", dc - hs2, 35);
    chk("b2b_bits", cap_bits[0] & 64'hFFFF, 64'h3CC3);
    chk("b2b_rises", rise_cnt[0] - r0, 16);
    chk("b2b_rclk_pulses", rclk_pulse[0] - rp0, 2);

    // Reset asserted for one cycle at cycle 10 of a transfer
    send(0, 64'hFF, 1'b0, hs);
    do begin
      @(negedge clk);
      #1;
    end while (cyc < hs + 10);
    rp0 = rclk_pulse[0];
    d0  = done_cnt[0];
    chk("busy_before_rst", busy_w[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("ready_during_rst", ready_w[0], 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_outputs", {srclk_w[0], rclk_w[0], oe_n_w[0], busy_w[0]}, 4'b0010);
    #1;
    chk("midrst_ready_after", ready_w[0], 1'b1);
    repeat (60) @(negedge clk);
    #1;
    chk("midrst_no_rclk", rclk_pulse[0] - rp0, 0);
    chk("midrst_no_done", done_cnt[0] - d0, 0);
    chk("midrst_oe_n_held", oe_n_w[0], 1'b1);

`ifdef SHIFT_LATCH_CTRL_READBACK_EN
    // Readback through the chain model: second transfer returns the first word
    d0 = done_cnt[0];
    send(0, 64'h5A, 1'b0, hs);
    wait_done(0, d0 + 1, dc);
    send(0, 64'h96, 1'b0, hs);
    wait_done(0, d0 + 2, dc);
    chk("readback_dout", dout0, 8'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
